id_ctrl_stage: RTL and testbench



---
 rtl/ctrl_pkg.sv | 74 +++++++
 rtl/load_use_detect.sv | 24 ++
 rtl/id_ctrl_stage.sv | 219 +++++++++++++++++++++
 tb/tb_id_ctrl_stage.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared decode-stage definitions: opcode/func encodings, ALU codes,
// memtoreg encodings, FSM state type and the control-bundle payload.
package ctrl_pkg;

    localparam int unsigned OP_W       = 6;
    localparam int unsigned FUNC_W     = 6;
    localparam int unsigned ALU_CODE_W = 4;
    localparam int unsigned MTR_W      = 2;

    // Opcodes
    localparam logic [OP_W-1:0] OP_LW     = 6'b000000;
    localparam logic [OP_W-1:0] OP_SW     = 6'b000001;
    localparam logic [OP_W-1:0] OP_BEQ    = 6'b000010;
    localparam logic [OP_W-1:0] OP_J      = 6'b000011;
    localparam logic [OP_W-1:0] OP_RTYPE  = 6'b000100;
    localparam logic [OP_W-1:0] OP_LUI    = 6'b000101;
    localparam logic [OP_W-1:0] OP_ANDI   = 6'b000110;
    localparam logic [OP_W-1:0] OP_SLTIMM = 6'b000111;
    localparam logic [OP_W-1:0] OP_SLTI   = 6'b001000;
    localparam logic [OP_W-1:0] OP_XORI   = 6'b001001;

    // R-type function codes
    localparam logic [FUNC_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNC_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNC_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNC_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNC_W-1:0] FN_SLT = 6'b101010;
    localparam logic [FUNC_W-1:0] FN_MUL = 6'b011000;

    // ALU operation codes; the top zero-extends these to its ALU_W
    localparam logic [ALU_CODE_W-1:0] ALU_NONE = 4'd0;
    localparam logic [ALU_CODE_W-1:0] ALU_OR   = 4'd1;
    localparam logic [ALU_CODE_W-1:0] ALU_ADD  = 4'd2;
    localparam logic [ALU_CODE_W-1:0] ALU_AND  = 4'd3;
    localparam logic [ALU_CODE_W-1:0] ALU_XOR  = 4'd4;
    localparam logic [ALU_CODE_W-1:0] ALU_SUB  = 4'd6;
    localparam logic [ALU_CODE_W-1:0] ALU_SLT  = 4'd7;
    localparam logic [ALU_CODE_W-1:0] ALU_MUL  = 4'd8;
    localparam logic [ALU_CODE_W-1:0] ALU_LUI  = 4'd9;

    // Write-back source select
    localparam logic [MTR_W-1:0] MTR_ALU   = 2'b00;
    localparam logic [MTR_W-1:0] MTR_MEM   = 2'b01;
    localparam logic [MTR_W-1:0] MTR_UPPER = 2'b10;

    typedef enum logic {
        RUN      = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    // Control half of the ID/EX register
    typedef struct packed {
        logic [MTR_W-1:0]      memtoreg;
        logic                  memwrite;
        logic                  memread;
        logic                  branch;
        logic                  jump;
        logic                  alusrc;
        logic                  regdst;
        logic                  regwrite;
        logic [ALU_CODE_W-1:0] alu;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // Result of decoding one instruction
    typedef struct packed {
        logic  legal;
        logic  is_mul;
        logic  reads_rt;
        ctrl_t ctrl;
    } dec_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator.
// Ports: ex_memread/ex_valid/ex_dest - registered bundle of the instruction in EX;
//        rs/rt - source fields of the instruction in ID; reads_rt - ID instruction
//        consumes rt; hazard - EX load writes a register the ID instruction reads.
module load_use_detect #(
    parameter int unsigned REG_W = 5
) (
    input  logic             ex_memread,
    input  logic             ex_valid,
    input  logic [REG_W-1:0] ex_dest,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             reads_rt,
    output logic             hazard
);

    logic match_rs;
    logic match_rt;

    assign match_rs = (ex_dest == rs);
    assign match_rt = reads_rt && (ex_dest == rt);
    assign hazard   = ex_memread && ex_valid && (match_rs || match_rt);

endmodule

// File: rtl/id_ctrl_stage.sv
// Decode-stage control generator: decodes opcode/func into the control
// bundle and registers it as the control half of ID/EX. Handles load-use
// stalls, flush bubbles and multi-cycle mul occupancy.
// Ports: clk/reset - clock, async active-high reset;
//        valid_in/opcode/func/rs/rt/rd - IF/ID instruction;
//        flush - kill the ID instruction; hold - freeze the stage;
//        memtoreg..regwrite/aluControl/dest_reg/valid_out - registered bundle;
//        illegal - one-cycle undecodable-instruction pulse;
//        stall_out - combinational stall to PC and IF/ID.
module id_ctrl_stage
    import ctrl_pkg::*;
#(
    parameter int unsigned ALU_W      = 4,
    parameter int unsigned REG_W      = 5,
    parameter int unsigned MUL_CYCLES = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic [REG_W-1:0] rd,
    input  logic             flush,
    input  logic             hold,
    output logic [1:0]       memtoreg,
    output logic             memwrite,
    output logic             memRead,
    output logic             branch,
    output logic             jump,
    output logic             aluSrc,
    output logic             regdst,
    output logic             regwrite,
    output logic [ALU_W-1:0] aluControl,
    output logic [REG_W-1:0] dest_reg,
    output logic             valid_out,
    output logic             illegal,
    output logic             stall_out
);

    localparam int unsigned CNT_W    = $clog2(MUL_CYCLES) + 1;
    // Busy cycles remaining after the first bubble; unused when mul is single-cycle
    localparam int unsigned CNT_INIT = (MUL_CYCLES > 1) ? (MUL_CYCLES - 2) : 0;

    // Decode table; illegal encodings come back as a bubble with legal=0
    function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fn);
        dec_t d;
        d       = '0;
        d.legal = 1'b1;
        case (op)
            OP_LW: begin
                d.ctrl.memread  = 1'b1;
                d.ctrl.memtoreg = MTR_MEM;
                d.ctrl.regwrite = 1'b1;
                d.ctrl.alusrc   = 1'b1;
                d.ctrl.alu      = ALU_ADD;
            end
            OP_SW: begin
                d.ctrl.memwrite = 1'b1;
                d.ctrl.alusrc   = 1'b1;
                d.ctrl.alu      = ALU_ADD;
                d.reads_rt      = 1'b1;
            end
            OP_BEQ: begin
                d.ctrl.branch = 1'b1;
                d.ctrl.alu    = ALU_SUB;
                d.reads_rt    = 1'b1;
            end
            OP_J: begin
                d.ctrl.jump = 1'b1;
            end
            OP_RTYPE: begin
                d.ctrl.regdst   = 1'b1;
                d.ctrl.regwrite = 1'b1;
                d.reads_rt      = 1'b1;
                case (fn)
                    FN_ADD:  d.ctrl.alu = ALU_ADD;
                    FN_SUB:  d.ctrl.alu = ALU_SUB;
                    FN_AND:  d.ctrl.alu = ALU_AND;
                    FN_OR:   d.ctrl.alu = ALU_OR;
                    FN_SLT:  d.ctrl.alu = ALU_SLT;
                    FN_MUL: begin
                        d.ctrl.alu = ALU_MUL;
                        d.is_mul   = 1'b1;
                    end
                    default: d.legal = 1'b0;
                endcase
            end
            OP_LUI: begin
                d.ctrl.memtoreg = MTR_UPPER;
                d.ctrl.regwrite = 1'b1;
                d.ctrl.alusrc   = 1'b1;
                d.ctrl.alu      = ALU_LUI;
            end
            OP_ANDI: begin
                d.ctrl.regwrite = 1'b1;
                d.ctrl.alusrc   = 1'b1;
                d.ctrl.alu      = ALU_AND;
            end
            OP_SLTIMM, OP_SLTI: begin
                d.ctrl.regwrite = 1'b1;
                d.ctrl.alusrc   = 1'b1;
                d.ctrl.alu      = ALU_SLT;
            end
            OP_XORI: begin
                d.ctrl.regwrite = 1'b1;
                d.ctrl.alusrc   = 1'b1;
                d.ctrl.alu      = ALU_XOR;
            end
            default: d.legal = 1'b0;
        endcase
        // reads_rt follows the opcode so a bad func still honours rt dependencies
        if (!d.legal) begin
            d.ctrl   = CTRL_BUBBLE;
            d.is_mul = 1'b0;
        end
        return d;
    endfunction

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    ctrl_t            ctrl_q, ctrl_n;
    logic             valid_q, valid_n;
    logic             illegal_q, illegal_n;
    logic [REG_W-1:0] dest_q, dest_n;
    dec_t             dec;
    logic             hazard_raw;
    logic             hazard;

    assign dec = decode(opcode, func);

    // Load-use check against the registered bundle now in EX
    load_use_detect #(
        .REG_W (REG_W)
    ) u_load_use_detect (
        .ex_memread (ctrl_q.memread),
        .ex_valid   (valid_q),
        .ex_dest    (dest_q),
        .rs         (rs),
        .rt         (rt),
        .reads_rt   (dec.reads_rt),
        .hazard     (hazard_raw)
    );

    assign hazard = hazard_raw && valid_in;

    // Next-state and next-bundle selection
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        ctrl_n    = CTRL_BUBBLE;
        valid_n   = 1'b0;
        dest_n    = '0;
        illegal_n = 1'b0;

        // In MUL_BUSY the stall is unconditional; in RUN a flush overrides the hazard
        stall_out = (state == MUL_BUSY) || (hazard && !flush);

        if (hold) begin
            ctrl_n    = ctrl_q;
            valid_n   = valid_q;
            dest_n    = dest_q;
            illegal_n = illegal_q;
        end else if (state == MUL_BUSY) begin
            // A flush here targets a younger instruction; the mul count keeps running
            if (cnt == '0) begin
                state_n = RUN;
            end else begin
                cnt_n = cnt - CNT_W'(1);
            end
        end else if (!flush && !hazard && valid_in) begin
            if (dec.legal) begin
                ctrl_n  = dec.ctrl;
                valid_n = 1'b1;
                dest_n  = dec.ctrl.regdst ? rd : rt;
                if (dec.is_mul && (MUL_CYCLES > 1)) begin
                    state_n = MUL_BUSY;
                    cnt_n   = CNT_W'(CNT_INIT);
                end
            end else begin
                illegal_n = 1'b1;
            end
        end
    end

    // ID/EX control register and FSM state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            cnt       <= '0;
            ctrl_q    <= CTRL_BUBBLE;
            valid_q   <= 1'b0;
            dest_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            ctrl_q    <= ctrl_n;
            valid_q   <= valid_n;
            dest_q    <= dest_n;
            illegal_q <= illegal_n;
        end
    end

    assign memtoreg   = ctrl_q.memtoreg;
    assign memwrite   = ctrl_q.memwrite;
    assign memRead    = ctrl_q.memread;
    assign branch     = ctrl_q.branch;
    assign jump       = ctrl_q.jump;
    assign aluSrc     = ctrl_q.alusrc;
    assign regdst     = ctrl_q.regdst;
    assign regwrite   = ctrl_q.regwrite;
    assign aluControl = ALU_W'(ctrl_q.alu);
    assign dest_reg   = dest_q;
    assign valid_out  = valid_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Self-checking bench for id_ctrl_stage: directed scenarios plus a
// randomized run compared against a cycle-level behavioural model.
module tb_id_ctrl_stage;

    localparam int unsigned ALU_W      = 4;
    localparam int unsigned REG_W      = 5;
    localparam int unsigned MUL_CYCLES = 3;

    localparam logic [5:0] O_LW = 6'd0, O_SW = 6'd1, O_BEQ = 6'd2, O_J = 6'd3, O_R = 6'd4;
    localparam logic [5:0] O_LUI = 6'd5, O_ANDI = 6'd6, O_SLTIMM = 6'd7, O_SLTI = 6'd8, O_XORI = 6'd9;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
    localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010, F_MUL = 6'b011000;

    logic             clk = 1'b0;
    logic             reset;
    logic             valid_in;
    logic [5:0]       opcode, func;
    logic [REG_W-1:0] rs, rt, rd;
    logic             flush, hold;
    logic [1:0]       memtoreg;
    logic             memwrite, memRead, branch, jump, aluSrc, regdst, regwrite;
    logic [ALU_W-1:0] aluControl;
    logic [REG_W-1:0] dest_reg;
    logic             valid_out, illegal, stall_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: expected registered outputs and the number of mul bubbles still owed
    logic [19:0] m_out;
    int          m_busy;

    always #5 clk = ~clk;

    id_ctrl_stage #(
        .ALU_W      (ALU_W),
        .REG_W      (REG_W),
        .MUL_CYCLES (MUL_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_in   (valid_in),
        .opcode     (opcode),
        .func       (func),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .flush      (flush),
        .hold       (hold),
        .memtoreg   (memtoreg),
        .memwrite   (memwrite),
        .memRead    (memRead),
        .branch     (branch),
        .jump       (jump),
        .aluSrc     (aluSrc),
        .regdst     (regdst),
        .regwrite   (regwrite),
        .aluControl (aluControl),
        .dest_reg   (dest_reg),
        .valid_out  (valid_out),
        .illegal    (illegal),
        .stall_out  (stall_out)
    );

    // Layout: {memtoreg[2], memwrite, memRead, branch, jump, aluSrc, regdst, regwrite, alu[4], dest[5], valid, illegal}
    function automatic logic [19:0] dut_vec();
        return {memtoreg, memwrite, memRead, branch, jump, aluSrc, regdst, regwrite,
                aluControl, dest_reg, valid_out, illegal};
    endfunction

    // Instruction semantics as a table of what each instruction needs
    function automatic logic [19:0] ref_bundle(input logic [5:0] op, input logic [5:0] fn,
                                               input logic [4:0] t, input logic [4:0] d,
                                               output logic ok, output logic is_mul);
        logic [1:0] wb_src;
        logic       st, ld, br, jp, imm, to_rd, wr;
        logic [3:0] alu;
        {wb_src, st, ld, br, jp, imm, to_rd, wr, alu} = '0;
        ok = 1'b1;
        is_mul = 1'b0;
        case (op)
            O_LW:   begin ld = 1; wb_src = 2'b01; wr = 1; imm = 1; alu = 4'd2; end
            O_SW:   begin st = 1; imm = 1; alu = 4'd2; end
            O_BEQ:  begin br = 1; alu = 4'd6; end
            O_J:    begin jp = 1; end
            O_LUI:  begin wb_src = 2'b10; wr = 1; imm = 1; alu = 4'd9; end
            O_ANDI: begin wr = 1; imm = 1; alu = 4'd3; end
            O_SLTIMM, O_SLTI: begin wr = 1; imm = 1; alu = 4'd7; end
            O_XORI: begin wr = 1; imm = 1; alu = 4'd4; end
            O_R: begin
                wr = 1; to_rd = 1;
                if (fn == F_ADD) alu = 4'd2;
                else if (fn == F_SUB) alu = 4'd6;
                else if (fn == F_AND) alu = 4'd3;
                else if (fn == F_OR)  alu = 4'd1;
                else if (fn == F_SLT) alu = 4'd7;
                else if (fn == F_MUL) begin alu = 4'd8; is_mul = 1'b1; end
                else ok = 1'b0;
            end
            default: ok = 1'b0;
        endcase
        return {wb_src, st, ld, br, jp, imm, to_rd, wr, alu, (to_rd ? d : t), 1'b1, 1'b0};
    endfunction

    function automatic logic model_hazard();
        logic uses_rt;
        logic ex_load;
        logic [4:0] ex_dest;
        uses_rt = (opcode == O_R) || (opcode == O_SW) || (opcode == O_BEQ);
        ex_load = m_out[16] && m_out[1];
        ex_dest = m_out[6:2];
        return valid_in && ex_load && ((ex_dest == rs) || (uses_rt && (ex_dest == rt)));
    endfunction

    function automatic logic model_stall();
        return (m_busy > 0) || (model_hazard() && !flush);
    endfunction

    task automatic set_in(input logic v, input logic [5:0] op, input logic [5:0] fn,
                          input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                          input logic fl, input logic hd);
        valid_in = v; opcode = op; func = fn; rs = s; rt = t; rd = d; flush = fl; hold = hd;
    endtask

    // One clock edge; the model advances alongside the DUT
    task automatic tick();
        logic [19:0] nxt;
        logic [19:0] b;
        logic ok, mul;
        nxt = m_out;
        if (!hold) begin
            if (m_busy > 0) begin
                nxt = '0;
                m_busy--;
            end else if (flush || model_hazard() || !valid_in) begin
                nxt = '0;
            end else begin
                b = ref_bundle(opcode, func, rt, rd, ok, mul);
                if (ok) begin
                    nxt = b;
                    if (mul) m_busy = int'(MUL_CYCLES) - 1;
                end else begin
                    nxt = 20'd1;
                end
            end
        end
        @(posedge clk);
        m_out = nxt;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        m_out = '0;
        m_busy = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        m_out = '0;
        m_busy = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        // Enter MUL_BUSY, then reset asynchronously mid-cycle
        set_in(1, O_R, F_MUL, 1, 2, 7, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++; if (dut_vec() !== 20'd0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 00000", dut_vec()); end
        n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall_out); end
        m_out = '0;
        m_busy = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_in(1, O_R, F_ADD, 1, 2, 3, 0, 0);
        @(negedge clk);
        n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL post_reset_stall: got %b expected 0", stall_out); end
        tick();
        n_checks++; if (aluControl !== 4'd2) begin n_fail++; $display("FAIL add_alu: got %0d expected 2", aluControl); end
        n_checks++; if ({regwrite, regdst, valid_out} !== 3'b111) begin n_fail++; $display("FAIL add_flags: got %b expected 111", {regwrite, regdst, valid_out}); end
        n_checks++; if (dest_reg !== 5'd3) begin n_fail++; $display("FAIL add_dest: got %0d expected 3", dest_reg); end
    endtask

    task automatic test_load_use();
        set_in(1, O_LW, 0, 0, 5, 0, 0, 0);
        tick();
        n_checks++; if ({memRead, memtoreg, dest_reg, valid_out} !== {1'b1, 2'b01, 5'd5, 1'b1}) begin n_fail++; $display("FAIL lw_bundle: got %b/%b/%0d/%b expected 1/01/5/1", memRead, memtoreg, dest_reg, valid_out); end
        set_in(1, O_R, F_ADD, 5, 1, 2, 0, 0);
        @(negedge clk);
        n_checks++; if (stall_out !== 1'b1) begin n_fail++; $display("FAIL loaduse_stall: got %b expected 1", stall_out); end
        tick();
        n_checks++; if (dut_vec() !== 20'd0) begin n_fail++; $display("FAIL loaduse_bubble: got %h expected 00000", dut_vec()); end
        @(negedge clk);
        n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL loaduse_clear: got %b expected 0", stall_out); end
        tick();
        n_checks++; if ({valid_out, dest_reg, aluControl} !== {1'b1, 5'd2, 4'd2}) begin n_fail++; $display("FAIL loaduse_reissue: got %b/%0d/%0d expected 1/2/2", valid_out, dest_reg, aluControl); end
    endtask

    task automatic test_mul();
        set_in(1, O_R, F_MUL, 1, 2, 7, 0, 0);
        tick();
        n_checks++; if ({aluControl, regwrite, dest_reg} !== {4'd8, 1'b1, 5'd7}) begin n_fail++; $display("FAIL mul_bundle: got %0d/%b/%0d expected 8/1/7", aluControl, regwrite, dest_reg); end
        set_in(1, O_R, F_ADD, 1, 2, 4, 0, 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++; if (stall_out !== 1'b1) begin n_fail++; $display("FAIL mul_stall%0d: got %b expected 1", k, stall_out); end
            tick();
            n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL mul_bubble%0d: got %b expected 0", k, valid_out); end
        end
        @(negedge clk);
        n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL mul_end_stall: got %b expected 0", stall_out); end
        tick();
        n_checks++; if ({valid_out, dest_reg} !== {1'b1, 5'd4}) begin n_fail++; $display("FAIL mul_next: got %b/%0d expected 1/4", valid_out, dest_reg); end
    endtask

    task automatic test_flush();
        set_in(1, O_LW, 0, 0, 6, 0, 0, 0);
        tick();
        // sw depends on the load, but the flush wins and suppresses the stall
        set_in(1, O_SW, 0, 6, 1, 0, 1, 0);
        @(negedge clk);
        n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b expected 0", stall_out); end
        tick();
        n_checks++; if ({memwrite, valid_out} !== 2'b00) begin n_fail++; $display("FAIL flush_bubble: got %b%b expected 00", memwrite, valid_out); end
        set_in(1, O_SW, 0, 6, 1, 0, 0, 0);
        tick();
        n_checks++; if ({memwrite, aluSrc, valid_out, dest_reg} !== {3'b111, 5'd1}) begin n_fail++; $display("FAIL sw_bundle: got %b%b%b/%0d expected 111/1", memwrite, aluSrc, valid_out, dest_reg); end
    endtask

    task automatic test_hold_busy();
        set_in(1, O_R, F_MUL, 3, 2, 9, 0, 0);
        tick();
        set_in(1, O_R, F_ADD, 1, 2, 4, 0, 1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++; if (stall_out !== 1'b1) begin n_fail++; $display("FAIL hold_stall%0d: got %b expected 1", k, stall_out); end
            tick();
            n_checks++; if ({aluControl, valid_out, dest_reg} !== {4'd8, 1'b1, 5'd9}) begin n_fail++; $display("FAIL hold_frozen%0d: got %0d/%b/%0d expected 8/1/9", k, aluControl, valid_out, dest_reg); end
        end
        hold = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++; if (stall_out !== 1'b1) begin n_fail++; $display("FAIL hold_busy_stall%0d: got %b expected 1", k, stall_out); end
            tick();
            n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL hold_busy_bubble%0d: got %b expected 0", k, valid_out); end
        end
        @(negedge clk);
        n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL hold_end_stall: got %b expected 0", stall_out); end
        tick();
        n_checks++; if ({valid_out, dest_reg} !== {1'b1, 5'd4}) begin n_fail++; $display("FAIL hold_next: got %b/%0d expected 1/4", valid_out, dest_reg); end
    endtask

    task automatic test_illegal();
        set_in(1, 6'b111111, 0, 0, 0, 0, 0, 0);
        tick();
        n_checks++; if ({illegal, valid_out} !== 2'b10) begin n_fail++; $display("FAIL illegal_op: got %b%b expected 10", illegal, valid_out); end
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_pulse: got %b expected 0", illegal); end
        set_in(1, O_R, 6'b000001, 1, 2, 3, 0, 0);
        tick();
        n_checks++; if ({illegal, valid_out, regwrite} !== 3'b100) begin n_fail++; $display("FAIL illegal_func: got %b%b%b expected 100", illegal, valid_out, regwrite); end
        set_in(1, O_ANDI, 0, 1, 2, 3, 0, 0);
        tick();
        n_checks++; if ({illegal, valid_out, aluControl, dest_reg} !== {2'b01, 4'd3, 5'd2}) begin n_fail++; $display("FAIL andi_after_illegal: got %b%b/%0d/%0d expected 01/3/2", illegal, valid_out, aluControl, dest_reg); end
    endtask

    task automatic test_random();
        logic [5:0] ops [12];
        logic [5:0] fns [7];
        ops = '{O_LW, O_SW, O_BEQ, O_J, O_R, O_LUI, O_ANDI, O_SLTIMM, O_SLTI, O_XORI, 6'b111111, 6'b010101};
        fns = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_MUL, 6'b000111};
        do_reset();
        for (int c = 0; c < 600; c++) begin
            set_in(($urandom % 8) != 0,
                   ($urandom % 3 == 0) ? O_LW : ops[$urandom % 12],
                   fns[$urandom % 7],
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   ($urandom % 10) == 0, ($urandom % 12) == 0);
            @(negedge clk);
            n_checks++; if (stall_out !== model_stall()) begin n_fail++; $display("FAIL rand_stall c=%0d: got %b expected %b", c, stall_out, model_stall()); end
            tick();
            n_checks++; if (dut_vec() !== m_out) begin n_fail++; $display("FAIL rand_bundle c=%0d: got %h expected %h", c, dut_vec(), m_out); end
        end
    endtask

    initial begin
        m_out = '0;
        m_busy = 0;
        test_reset();
        test_load_use();
        test_mul();
        test_flush();
        test_hold_busy();
        test_illegal();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
